// File: rtl/lsu_bus_adapter.sv
// Load/store adapter from the memory-access stage onto a 32-bit data bus.
// Splits each request into one or two beats, steers byte lanes and enforces a per-beat timeout.
module lsu_bus_adapter #(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [XLEN-1:0] mem_addr,
  input  logic [XLEN-1:0] mem_wdata,
  input  logic            mem_read_req,
  input  logic            mem_write_req,
  input  logic [2:0]      mem_size,
  output logic [XLEN-1:0] mem_rdata,
  output logic            mem_ready,
  output logic            mem_error,
  output logic            bus_req_valid,
  input  logic            bus_req_ready,
  output logic [XLEN-1:0] bus_addr,
  output logic            bus_we,
  output logic [31:0]     bus_wdata,
  output logic [3:0]      bus_wstrb,
  input  logic            bus_rsp_valid,
  input  logic [31:0]     bus_rsp_data,
  input  logic            bus_rsp_err
);

  typedef enum logic [2:0] {StIdle, StCheck, StReq, StRsp, StResp} state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic [2:0]        size_q, size_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic              beat_q, beat_d;
  logic              err_q, err_d;
  logic [15:0]       timer_q, timer_d;

  logic [1:0]  off;
  logic [63:0] wdata64;
  logic [31:0] shifted;
  logic [31:0] rword;
  logic [63:0] rmerge;
  logic        misalign;
  logic        fault;
  logic        expired;

  assign off     = addr_q[1:0];
  assign wdata64 = 64'(wdata_q);
  assign expired = timer_q >= 16'(TIMEOUT - 1);

  always_comb begin
    misalign = 1'b0;
    case (size_q)
      3'd1:    misalign = addr_q[0];
      3'd2:    misalign = addr_q[1:0] != 2'b00;
      3'd3:    misalign = addr_q[2:0] != 3'b000;
      default: misalign = 1'b0;
    endcase
  end

  assign fault = (rd_q && wr_q) || (size_q > 3'd3) || ((size_q == 3'd3) && (XLEN != 64)) ||
                 misalign;

  // Write lane steering; reads never assert strobes.
  always_comb begin
    bus_wstrb = 4'h0;
    bus_wdata = 32'h0;
    case (size_q)
      3'd0: begin
        bus_wstrb = 4'b0001 << off;
        bus_wdata = {24'h0, wdata64[7:0]} << {off, 3'b000};
      end
      3'd1: begin
        bus_wstrb = 4'b0011 << off;
        bus_wdata = {16'h0, wdata64[15:0]} << {off, 3'b000};
      end
      default: begin
        bus_wstrb = 4'hF;
        bus_wdata = beat_q ? wdata64[63:32] : wdata64[31:0];
      end
    endcase
    if (!wr_q) begin
      bus_wstrb = 4'h0;
    end
  end

  assign shifted = bus_rsp_data >> {off, 3'b000};

  always_comb begin
    case (size_q)
      3'd0:    rword = {24'h0, shifted[7:0]};
      3'd1:    rword = {16'h0, shifted[15:0]};
      default: rword = shifted;
    endcase
  end

  always_comb begin
    rmerge = 64'(rdata_q);
    if (beat_q) begin
      rmerge[63:32] = rword;
    end else begin
      rmerge[31:0] = rword;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    size_d  = size_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    beat_d  = beat_q;
    err_d   = err_q;
    timer_d = timer_q;
    unique case (state_q)
      StIdle: begin
        if (mem_read_req || mem_write_req) begin
          addr_d  = mem_addr;
          wdata_d = mem_wdata;
          size_d  = mem_size;
          rd_d    = mem_read_req;
          wr_d    = mem_write_req;
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = StCheck;
        end
      end
      StCheck: begin
        if (fault) begin
          err_d   = 1'b1;
          state_d = StResp;
        end else begin
          beat_d  = 1'b0;
          timer_d = 16'h0;
          state_d = StReq;
        end
      end
      StReq: begin
        timer_d = timer_q + 16'h1;
        if (bus_req_ready) begin
          state_d = StRsp;
        end else if (expired) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = StResp;
        end
      end
      StRsp: begin
        timer_d = timer_q + 16'h1;
        if (bus_rsp_valid) begin
          if (bus_rsp_err) begin
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = StResp;
          end else if ((size_q == 3'd3) && !beat_q) begin
            rdata_d = rmerge[XLEN-1:0];
            beat_d  = 1'b1;
            timer_d = 16'h0;
            state_d = StReq;
          end else begin
            rdata_d = (size_q == 3'd3) ? rmerge[XLEN-1:0] : XLEN'(rword);
            state_d = StResp;
          end
        end else if (expired) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = StResp;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      size_q  <= 3'd0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      beat_q  <= 1'b0;
      err_q   <= 1'b0;
      timer_q <= 16'h0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      size_q  <= size_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
      timer_q <= timer_d;
    end
  end

  assign mem_rdata     = rdata_q;
  assign mem_ready     = (state_q == StResp) && !err_q;
  assign mem_error     = (state_q == StResp) && err_q;
  assign bus_req_valid = state_q == StReq;
  assign bus_we        = wr_q;
  assign bus_addr      = {addr_q[XLEN-1:2], 2'b00} + {{(XLEN-3){1'b0}}, beat_q, 2'b00};

endmodule

// File: tb/tb_lsu_bus_adapter.sv
// Directed bench for lsu_bus_adapter: a zero-wait bus responder logs beats into a queue that is
// checked against expected beats pushed when each request is driven.
module tb_lsu_bus_adapter;

  typedef struct packed {
    logic [63:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } beat_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [63:0] mem_addr = '0;
  logic [63:0] mem_wdata = '0;
  logic        mem_read_req = 1'b0;
  logic        mem_write_req = 1'b0;
  logic [2:0]  mem_size = '0;
  logic [63:0] mem_rdata;
  logic        mem_ready;
  logic        mem_error;
  logic        bus_req_valid;
  logic        bus_req_ready = 1'b1;
  logic [63:0] bus_addr;
  logic        bus_we;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_rsp_valid = 1'b0;
  logic [31:0] bus_rsp_data = '0;
  logic        bus_rsp_err = 1'b0;

  int total = 0;
  int bad = 0;

  beat_t       exp_q[$];
  beat_t       obs_q[$];
  logic [32:0] rsp_q[$];   // {err, data} served per accepted beat
  logic        pending = 1'b0;
  logic [32:0] cur_rsp = '0;
  logic        stray = 1'b0;

  lsu_bus_adapter #(.XLEN(64), .TIMEOUT(8)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_read_req  (mem_read_req),
    .mem_write_req (mem_write_req),
    .mem_size      (mem_size),
    .mem_rdata     (mem_rdata),
    .mem_ready     (mem_ready),
    .mem_error     (mem_error),
    .bus_req_valid (bus_req_valid),
    .bus_req_ready (bus_req_ready),
    .bus_addr      (bus_addr),
    .bus_we        (bus_we),
    .bus_wdata     (bus_wdata),
    .bus_wstrb     (bus_wstrb),
    .bus_rsp_valid (bus_rsp_valid),
    .bus_rsp_data  (bus_rsp_data),
    .bus_rsp_err   (bus_rsp_err)
  );

  always #5 clk = ~clk;

  // Bus responder: answers each accepted beat on the following cycle.
  initial begin
    forever begin
      @(negedge clk);
      bus_rsp_valid = pending | stray;
      bus_rsp_data  = pending ? cur_rsp[31:0] : 32'hDEAD_0000;
      bus_rsp_err   = pending & cur_rsp[32];
      pending = 1'b0;
      if (resetn && bus_req_valid && bus_req_ready) begin
        obs_q.push_back('{addr: bus_addr, we: bus_we, wdata: bus_we ? bus_wdata : 32'h0,
                          wstrb: bus_wstrb});
        cur_rsp = (rsp_q.size() != 0) ? rsp_q.pop_front() : 33'h0;
        pending = 1'b1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog obs=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", name, obs, exp);
    end
  endtask

  task automatic run(input logic rd, input logic wr, input logic [63:0] addr,
                     input logic [2:0] size, input logic [63:0] wdata,
                     output int lat, output logic rdy, output logic err,
                     output logic [63:0] rdata, output int vcnt);
    @(negedge clk);
    mem_read_req  = rd;
    mem_write_req = wr;
    mem_addr      = addr;
    mem_size      = size;
    mem_wdata     = wdata;
    lat = -1; rdy = 1'b0; err = 1'b0; rdata = '0; vcnt = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (bus_req_valid) vcnt++;
      if (mem_ready || mem_error) begin
        lat   = c;
        rdy   = mem_ready;
        err   = mem_error;
        rdata = mem_rdata;
        break;
      end
    end
    mem_read_req  = 1'b0;
    mem_write_req = 1'b0;
    @(negedge clk);
    chk("pulse_clear", {mem_ready, mem_error}, 2'b00);
  endtask

  task automatic chk_beats(input string name);
    chk({name, "_nbeats"}, obs_q.size(), exp_q.size());
    while (obs_q.size() != 0 && exp_q.size() != 0) begin
      chk({name, "_beat"}, obs_q.pop_front(), exp_q.pop_front());
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int          lat, vcnt, pulses;
    logic        rdy, err;
    logic [63:0] rdata;

    #1;
    chk("reset_outs", {mem_ready, mem_error, bus_req_valid, bus_we, bus_wstrb, mem_rdata},
        '0);
    chk("reset_addr", bus_addr, 64'h0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    // LBU 0x1003
    rsp_q.push_back({1'b0, 32'hA1B2C3D4});
    exp_q.push_back('{addr: 64'h1000, we: 1'b0, wdata: 32'h0, wstrb: 4'h0});
    run(1'b1, 1'b0, 64'h1003, 3'd0, 64'h0, lat, rdy, err, rdata, vcnt);
    chk("lbu_resp", {rdy, err}, 2'b10);
    chk("lbu_lat", lat, 4);
    chk("lbu_rdata", rdata, 64'hA1);
    chk_beats("lbu");

    // SH 0x2002
    rsp_q.push_back({1'b0, 32'h0});
    exp_q.push_back('{addr: 64'h2000, we: 1'b1, wdata: 32'hBEEF0000, wstrb: 4'b1100});
    run(1'b0, 1'b1, 64'h2002, 3'd1, 64'hDEADBEEF, lat, rdy, err, rdata, vcnt);
    chk("sh_resp", {rdy, err}, 2'b10);
    chk("sh_lat", lat, 4);
    chk_beats("sh");

    // SD 0x3000: two beats, one completion
    rsp_q.push_back({1'b0, 32'h0});
    rsp_q.push_back({1'b0, 32'h0});
    exp_q.push_back('{addr: 64'h3000, we: 1'b1, wdata: 32'h55667788, wstrb: 4'hF});
    exp_q.push_back('{addr: 64'h3004, we: 1'b1, wdata: 32'h11223344, wstrb: 4'hF});
    run(1'b0, 1'b1, 64'h3000, 3'd3, 64'h11223344_55667788, lat, rdy, err, rdata, vcnt);
    chk("sd_resp", {rdy, err}, 2'b10);
    chk("sd_lat", lat, 6);
    chk_beats("sd");

    // LW 0x4002: misaligned, no bus traffic
    run(1'b1, 1'b0, 64'h4002, 3'd2, 64'h0, lat, rdy, err, rdata, vcnt);
    chk("lw_mis_resp", {rdy, err}, 2'b01);
    chk("lw_mis_lat", lat, 2);
    chk("lw_mis_valid", vcnt, 0);
    chk_beats("lw_mis");

    // LD 0x6000: data assembled from both beats
    rsp_q.push_back({1'b0, 32'h01234567});
    rsp_q.push_back({1'b0, 32'h89ABCDEF});
    exp_q.push_back('{addr: 64'h6000, we: 1'b0, wdata: 32'h0, wstrb: 4'h0});
    exp_q.push_back('{addr: 64'h6004, we: 1'b0, wdata: 32'h0, wstrb: 4'h0});
    run(1'b1, 1'b0, 64'h6000, 3'd3, 64'h0, lat, rdy, err, rdata, vcnt);
    chk("ld_resp", {rdy, err}, 2'b10);
    chk("ld_rdata", rdata, 64'h89ABCDEF_01234567);
    chk_beats("ld");

    // LD 0x5000 with bus error on beat 0
    rsp_q.push_back({1'b1, 32'hFFFFFFFF});
    exp_q.push_back('{addr: 64'h5000, we: 1'b0, wdata: 32'h0, wstrb: 4'h0});
    run(1'b1, 1'b0, 64'h5000, 3'd3, 64'h0, lat, rdy, err, rdata, vcnt);
    chk("ld_err_resp", {rdy, err}, 2'b01);
    chk("ld_err_rdata", rdata, 64'h0);
    chk("ld_err_lat", lat, 4);
    chk_beats("ld_err");

    // LH 0x7002, then rdata held while idle
    rsp_q.push_back({1'b0, 32'hA1B2C3D4});
    exp_q.push_back('{addr: 64'h7000, we: 1'b0, wdata: 32'h0, wstrb: 4'h0});
    run(1'b1, 1'b0, 64'h7002, 3'd1, 64'h0, lat, rdy, err, rdata, vcnt);
    chk("lh_rdata", rdata, 64'hA1B2);
    chk("lh_rdata_hold", mem_rdata, 64'hA1B2);
    chk_beats("lh");

    // Read and write both asserted
    run(1'b1, 1'b1, 64'h8000, 3'd2, 64'h0, lat, rdy, err, rdata, vcnt);
    chk("rdwr_resp", {rdy, err}, 2'b01);
    chk("rdwr_valid", vcnt, 0);

    // Timeout with ready stuck low
    bus_req_ready = 1'b0;
    run(1'b1, 1'b0, 64'h9000, 3'd2, 64'h0, lat, rdy, err, rdata, vcnt);
    chk("to_resp", {rdy, err}, 2'b01);
    chk("to_valid_cycles", vcnt, 8);
    chk("to_lat", lat, 10);
    chk("to_valid_low", bus_req_valid, 1'b0);
    chk_beats("to");

    // Stray response while idle must be ignored
    pulses = 0;
    stray = 1'b1;
    repeat (3) begin
      @(negedge clk);
      pulses += int'(mem_ready) + int'(mem_error);
    end
    stray = 1'b0;
    repeat (3) begin
      @(negedge clk);
      pulses += int'(mem_ready) + int'(mem_error);
    end
    chk("stray_ignored", pulses, 0);

    // Reset mid-REQ
    mem_read_req = 1'b1;
    mem_addr     = 64'hA000;
    mem_size     = 3'd2;
    for (int c = 0; c < 10 && !bus_req_valid; c++) @(negedge clk);
    chk("mid_req_reached", bus_req_valid, 1'b1);
    resetn = 1'b0;
    mem_read_req = 1'b0;
    #1;
    chk("mid_reset_outs", {mem_ready, mem_error, bus_req_valid, bus_we, bus_wstrb, mem_rdata},
        '0);
    chk("mid_reset_addr", bus_addr, 64'h0);
    @(negedge clk);
    resetn = 1'b1;
    bus_req_ready = 1'b1;
    pulses = 0;
    repeat (4) begin
      @(negedge clk);
      pulses += int'(mem_ready) + int'(mem_error) + int'(bus_req_valid);
    end
    chk("post_reset_quiet", pulses, 0);
    chk_beats("mid_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
